// File: rtl/rv_core_pkg.sv
// rv_core_pkg: shared types and constants for the RV32I core front end
package rv_core_pkg;
  typedef enum logic [1:0] {FETCH, WAIT, VALID, HALT} fetch_state_e;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction memory request/response channel
interface inst_fetch_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  modport master (output req_valid, addr, input req_ready, rsp_valid, rsp_data);
  modport slave (input req_valid, addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/inst_fetch_npc.sv
// inst_fetch_npc: next-PC selection and word-alignment check
module inst_fetch_npc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_sel_i,
  input  logic [XLEN-1:0] alu_out_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] target_o,
  output logic            misalign_hit_o
);
  assign pc_plus4_o     = pc_i + XLEN'(4);
  assign target_o       = pc_sel_i ? (alu_out_i & ~XLEN'(1)) : pc_plus4_o;
  assign misalign_hit_o = target_o[1];
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC owner and single-outstanding instruction fetch FSM
module inst_fetch
  import rv_core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst_n,
  inst_fetch_if.master     imem,
  output logic             inst_valid_o,
  output logic [XLEN-1:0]  inst_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc_plus4_o,
  input  logic             inst_ready_i,
  input  logic             pc_sel_i,
  input  logic [XLEN-1:0]  alu_out_i,
  output logic             misalign_o,
  output logic [31:0]      retire_cnt_o
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, inst_q, inst_d, target;
  logic            misalign_q, misalign_d, misalign_hit;
  logic [31:0]     retire_cnt_q, retire_cnt_d;

  inst_fetch_npc #(.XLEN(XLEN)) u_npc (
    .pc_i           (pc_q),
    .pc_sel_i       (pc_sel_i),
    .alu_out_i      (alu_out_i),
    .pc_plus4_o     (pc_plus4_o),
    .target_o       (target),
    .misalign_hit_o (misalign_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= XLEN'(RV_NOP);
      misalign_q   <= 1'b0;
      retire_cnt_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      misalign_q   <= misalign_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Responses are only accepted in WAIT, so stale data after a reset is dropped
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    misalign_d   = misalign_q;
    retire_cnt_d = retire_cnt_q;
    unique case (state_q)
      FETCH: state_d = imem.req_ready ? WAIT : FETCH;
      WAIT: begin
        inst_d  = imem.rsp_valid ? imem.rsp_data : inst_q;
        state_d = imem.rsp_valid ? VALID : WAIT;
      end
      VALID: if (inst_ready_i) begin
        retire_cnt_d = retire_cnt_q + 32'd1;
        misalign_d   = misalign_q | misalign_hit;
        pc_d         = misalign_hit ? pc_q : target;
        state_d      = misalign_hit ? HALT : FETCH;
      end
      HALT: state_d = HALT;
    endcase
  end

  assign imem.req_valid = rst_n && state_q == FETCH;
  assign imem.addr      = pc_q;
  assign inst_valid_o   = state_q == VALID;
  assign inst_o         = inst_q;
  assign pc_o           = pc_q;
  assign misalign_o     = misalign_q;
  assign retire_cnt_o   = retire_cnt_q;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: table-driven retire sequences with a fetch scoreboard
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid, inst_ready, pc_sel, misalign;
  logic [31:0] inst, pc, pc_plus4, alu_out, retire_cnt;

  always #5 clk = ~clk;

  inst_fetch_if #(.XLEN(32)) imem ();

  inst_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (imem.master),
    .inst_valid_o (inst_valid),
    .inst_o       (inst),
    .pc_o         (pc),
    .pc_plus4_o   (pc_plus4),
    .inst_ready_i (inst_ready),
    .pc_sel_i     (pc_sel),
    .alu_out_i    (alu_out),
    .misalign_o   (misalign),
    .retire_cnt_o (retire_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic        sel;
    logic [31:0] alu;
    int          stall;
    int          delay;
    int          hold;
    logic [31:0] exp_pc;
    bit          halt;
  } vec_t;

  exp_t        sb[$];
  int          tests = 0, fails = 0;
  int          stall_n = 0, delay_n = 0, pend = -1;
  logic [31:0] pend_addr = 32'h0;
  bit          stale = 1'b0, acc_now = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h5A5A_0013);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model plus retire-side scoreboard, evaluated mid-cycle before each edge
  task automatic drive_mem();
    imem.req_ready = (stall_n == 0);
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = 32'h0;
    if (stale) begin
      imem.rsp_valid = 1'b1;
      imem.rsp_data  = 32'hDEAD_BEEF;
      stale = 1'b0;
    end else if (pend == 0) begin
      imem.rsp_valid = 1'b1;
      imem.rsp_data  = mem_word(pend_addr);
      pend = -1;
    end else if (pend > 0) pend--;
    acc_now = imem.req_valid && imem.req_ready;
    if (imem.req_valid && stall_n > 0) stall_n--;
    if (acc_now) begin
      pend_addr = imem.addr;
      sb.push_back('{imem.addr, mem_word(imem.addr)});
    end
    if (inst_valid && inst_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_empty: retire of pc %h with no expected fetch", pc);
      end else begin
        exp_t e = sb.pop_front();
        chk("sb_pc", pc, e.pc);
        chk("sb_inst", inst, e.inst);
      end
    end
  endtask

  task automatic tick();
    drive_mem();
    @(posedge clk);
    @(negedge clk);
    if (acc_now) pend = delay_n;
    inst_ready = 1'b0;
  endtask

  task automatic wait_valid(output int n, input logic [31:0] exp_addr);
    n = 0;
    while (!inst_valid && n < 60) begin
      if (imem.req_valid) chk("addr_hold", imem.addr, exp_addr);
      tick();
      n++;
    end
    if (!inst_valid) begin
      tests++;
      fails++;
      $display("FAIL wait_valid: inst_valid still 0 after %0d cycles", n);
    end
  endtask

  initial begin
    vec_t        v[7];
    int          n;
    logic [31:0] exp_cnt, prev_pc, held;
    v[0] = '{1'b1, 32'h0000_0010, 0, 0, 0, 32'h0000_0010, 1'b0};
    v[1] = '{1'b0, 32'hFFFF_FFF1, 0, 0, 0, 32'h0000_0014, 1'b0};
    v[2] = '{1'b1, 32'h0000_0101, 0, 0, 0, 32'h0000_0100, 1'b0};
    v[3] = '{1'b0, 32'h0000_0000, 3, 4, 5, 32'h0000_0104, 1'b0};
    v[4] = '{1'b1, 32'hFFFF_FFFC, 0, 1, 0, 32'hFFFF_FFFC, 1'b0};
    v[5] = '{1'b0, 32'h0000_0000, 0, 0, 2, 32'h0000_0000, 1'b0};
    v[6] = '{1'b1, 32'h0000_0102, 0, 0, 0, 32'h0000_0000, 1'b1};
    inst_ready = 1'b0;
    pc_sel     = 1'b0;
    alu_out    = 32'h0;
    imem.req_ready = 1'b0;
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = 32'h0;
    exp_cnt = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 32'(imem.req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_retire_cnt", retire_cnt, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0000_0013);
    rst_n = 1'b1;
    #1;
    chk("first_req_valid", 32'(imem.req_valid), 32'd1);
    chk("first_addr", imem.addr, 32'h0);
    tick();
    chk("cycle2_inst_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("cycle3_inst_valid", 32'(inst_valid), 32'd1);
    chk("cycle3_inst", inst, 32'h0050_0093);
    chk("cycle3_pc", pc, 32'h0);
    chk("cycle3_pc_plus4", pc_plus4, 32'h4);
    for (int i = 0; i < 7; i++) begin
      prev_pc = pc;
      stall_n = v[i].stall;
      delay_n = v[i].delay;
      inst_ready = 1'b1;
      pc_sel  = v[i].sel;
      alu_out = v[i].alu;
      tick();
      exp_cnt++;
      pc_sel  = 1'($urandom);
      alu_out = $urandom;
      chk("retire_cnt", retire_cnt, exp_cnt);
      if (v[i].halt) begin
        chk("halt_misalign", 32'(misalign), 32'd1);
        chk("halt_pc", pc, prev_pc);
        for (int k = 0; k < 4; k++) begin
          stale = 1'b1;
          chk("halt_req_valid", 32'(imem.req_valid), 32'd0);
          chk("halt_inst_valid", 32'(inst_valid), 32'd0);
          tick();
        end
        chk("halt_sticky", 32'(misalign), 32'd1);
      end else begin
        chk("misalign_clear", 32'(misalign), 32'd0);
        chk("next_req_valid", 32'(imem.req_valid), 32'd1);
        chk("next_addr", imem.addr, v[i].exp_pc);
        wait_valid(n, v[i].exp_pc);
        chk("fetch_latency", 32'(n), 32'(2 + v[i].stall + v[i].delay));
        chk("vec_pc", pc, v[i].exp_pc);
        chk("vec_pc_plus4", pc_plus4, v[i].exp_pc + 32'd4);
        held = inst;
        for (int k = 0; k < v[i].hold; k++) begin
          tick();
          chk("hold_inst_valid", 32'(inst_valid), 32'd1);
          chk("hold_inst", inst, held);
          chk("hold_pc", pc, v[i].exp_pc);
        end
      end
    end
    rst_n = 1'b0;
    sb.delete();
    pend = -1;
    stall_n = 0;
    #1;
    chk("rst2_misalign", 32'(misalign), 32'd0);
    chk("rst2_retire_cnt", retire_cnt, 32'd0);
    chk("rst2_inst", inst, 32'h0000_0013);
    @(negedge clk);
    rst_n = 1'b1;
    delay_n = 2;
    tick();
    chk("wait_before_reset", 32'(imem.req_valid), 32'd0);
    rst_n = 1'b0;
    sb.delete();
    pend = -1;
    #1;
    chk("midreset_pc", pc, 32'h0);
    chk("midreset_req_valid", 32'(imem.req_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    stale = 1'b1;
    delay_n = 1;
    wait_valid(n, 32'h0);
    chk("stale_dropped_inst", inst, 32'h0050_0093);
    chk("stale_dropped_pc", pc, 32'h0);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    inst_ready = 1'b1;
    pc_sel = 1'b0;
    tick();
    chk("retire_cnt_wrap", retire_cnt, 32'd0);
    chk("after_wrap_addr", imem.addr, 32'h4);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
